// File: rtl/opb_register_ppc2simulink_sync_if.sv
// OPB bus bundle for the software-to-fabric control register slave.
interface opb_register_ppc2simulink_sync_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_ppc2simulink_sync.sv
// OPB slave control register: PowerPC writes a 32-bit word presented to fabric with a strobe.
// Define OPB_REG_P2S_WRCOUNT_EN to add a read-only write counter at offset 0x4.
module opb_register_ppc2simulink_sync #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
    input  logic                               OPB_Clk,
    input  logic                               OPB_Rst,
    opb_register_ppc2simulink_sync_if.slave    bus,
    output logic [31:0]                        user_data_out,
    output logic                               user_data_strobe
);

    typedef enum logic [1:0] {IDLE, ACK, GUARD} state_t;

    state_t      state, state_nxt;
    logic [32:0] lo_diff, hi_diff;
    logic        hit, req, ack;
    logic [29:0] off_word;
    logic [31:0] wr_word, rd_word;
    logic [0:31] rdata;
    logic        strobe_q;
`ifdef OPB_REG_P2S_WRCOUNT_EN
    logic [31:0] wr_count;
`endif

    // 33-bit differences give the window test without constant-compare corner cases
    assign lo_diff  = {1'b0, bus.OPB_ABus} - {1'b0, C_BASEADDR};
    assign hi_diff  = {1'b0, C_HIGHADDR} - {1'b0, bus.OPB_ABus};
    assign hit      = !lo_diff[32] && !hi_diff[32];
    assign off_word = lo_diff[31:2];
    assign req      = bus.OPB_select && hit;

    logic unused_bits;
    assign unused_bits = ^{bus.OPB_seqAddr, lo_diff[1:0], hi_diff[31:0]};

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = ACK;
            ACK:     state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // BE[0] pairs with DBus[0:7], which is the most significant user byte
    always_comb begin
        wr_word = user_data_out;
        for (int b = 0; b < 4; b++)
            if (bus.OPB_BE[b]) wr_word[31-8*b -: 8] = bus.OPB_DBus[8*b +: 8];
    end

    always_comb begin
        rd_word = '0;
        if (off_word == 30'd0) rd_word = user_data_out;
`ifdef OPB_REG_P2S_WRCOUNT_EN
        else if (off_word == 30'd1) rd_word = wr_count;
`endif
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            user_data_out <= C_INIT_VALUE;
            strobe_q      <= 1'b0;
            rdata         <= '0;
`ifdef OPB_REG_P2S_WRCOUNT_EN
            wr_count      <= '0;
`endif
        end else begin
            strobe_q <= 1'b0;
            rdata    <= '0;
            if (state == IDLE && req) begin
                if (bus.OPB_RNW) begin
                    rdata <= rd_word;
                end else if (off_word == 30'd0 && |bus.OPB_BE) begin
                    user_data_out <= wr_word;
                    strobe_q      <= 1'b1;
`ifdef OPB_REG_P2S_WRCOUNT_EN
                    wr_count      <= wr_count + 32'd1;
`endif
                end
            end
        end
    end

    // Reset cuts the ack and strobe in the same cycle rather than one edge later
    assign ack              = (state == ACK) && !OPB_Rst;
    assign user_data_strobe = strobe_q && !OPB_Rst;

    assign bus.Sl_xferAck = ack;
    assign bus.Sl_DBus    = ack ? rdata : '0;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Directed bench for the OPB control register slave.
module tb_opb_register_ppc2simulink_sync;
    localparam logic [31:0] INIT = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] user_data_out;
    logic        user_data_strobe;
    int          errors = 0;
    int          checks = 0;

    opb_register_ppc2simulink_sync_if bus();

    opb_register_ppc2simulink_sync #(
        .C_BASEADDR   (32'h0000_0000),
        .C_HIGHADDR   (32'h0000_00FF),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5"),
        .C_INIT_VALUE (INIT)
    ) dut (
        .OPB_Clk          (clk),
        .OPB_Rst          (rst),
        .bus              (bus),
        .user_data_out    (user_data_out),
        .user_data_strobe (user_data_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request before edge N; returns #1 after edge N (the ACK cycle)
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                        input logic [31:0] data);
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = data;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        bus.OPB_select = 1'b0;
    endtask

    task automatic settle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_guard_ack"}, {31'd0, bus.Sl_xferAck}, 32'd0);
        chk({tag, "_guard_strobe"}, {31'd0, user_data_strobe}, 32'd0);
        chk({tag, "_guard_dbus"}, bus.Sl_DBus, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.OPB_ABus    = '0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", user_data_out, INIT);
        chk("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        chk("rst_dbus", bus.Sl_DBus, 32'd0);
        chk("rst_strobe", {31'd0, user_data_strobe}, 32'd0);

        // Request during reset is ignored; if it had been taken, ack shows once reset drops
        @(negedge clk);
        bus.OPB_ABus = 32'h0; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        bus.OPB_select = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_wins_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        xfer(32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
        chk("wr_full_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("wr_full_data", user_data_out, 32'hDEADBEEF);
        chk("wr_full_strobe", {31'd0, user_data_strobe}, 32'd1);
        chk("wr_full_dbus", bus.Sl_DBus, 32'd0);
        settle("wr_full");

        xfer(32'h0, 1'b0, 4'b0100, 32'h11223344);
        chk("wr_be1_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("wr_be1_data", user_data_out, 32'hDE22BEEF);
        chk("wr_be1_strobe", {31'd0, user_data_strobe}, 32'd1);
        settle("wr_be1");

        xfer(32'h0, 1'b0, 4'b0000, 32'hFFFFFFFF);
        chk("wr_be0_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("wr_be0_data", user_data_out, 32'hDE22BEEF);
        chk("wr_be0_strobe", {31'd0, user_data_strobe}, 32'd0);
        settle("wr_be0");

        xfer(32'h3, 1'b1, 4'b1111, 32'h0);
        chk("rd0_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("rd0_dbus", bus.Sl_DBus, 32'hDE22BEEF);
        chk("rd0_strobe", {31'd0, user_data_strobe}, 32'd0);
        settle("rd0");

        xfer(32'h10, 1'b0, 4'b1111, 32'h55555555);
        chk("wr10_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("wr10_data", user_data_out, 32'hDE22BEEF);
        settle("wr10");

        xfer(32'h10, 1'b1, 4'b1111, 32'h0);
        chk("rd10_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("rd10_dbus", bus.Sl_DBus, 32'd0);
        settle("rd10");

        // Out-of-window address held for five cycles never gets acked
        @(negedge clk);
        bus.OPB_ABus = 32'h100; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("miss_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        end
        bus.OPB_select = 1'b0;

        // Continuous select: acks no more often than every third cycle
        @(negedge clk);
        bus.OPB_ABus = 32'h0; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_ack", {31'd0, bus.Sl_xferAck}, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        bus.OPB_select = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset inside the ACK cycle of a write
        xfer(32'h0, 1'b0, 4'b1111, 32'h12345678);
        rst = 1'b1;
        #1;
        chk("rst_ack_cut", {31'd0, bus.Sl_xferAck}, 32'd0);
        chk("rst_ack_strobe", {31'd0, user_data_strobe}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_ack_data", user_data_out, INIT);
        rst = 1'b0;
        xfer(32'h0, 1'b1, 4'b1111, 32'h0);
        chk("post_rst_idle_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        chk("post_rst_dbus", bus.Sl_DBus, INIT);
        settle("post_rst");

        xfer(32'h0, 1'b0, 4'b1111, 32'h00000010);
        settle("cnt_w1");
        xfer(32'h0, 1'b0, 4'b0000, 32'h00000020);
        settle("cnt_w2");
        xfer(32'h0, 1'b0, 4'b0001, 32'h00000030);
        chk("cnt_w3_data", user_data_out, 32'h00000030);
        settle("cnt_w3");
        xfer(32'h4, 1'b0, 4'b1111, 32'h77777777);
        settle("cnt_w4");
        xfer(32'h4, 1'b1, 4'b1111, 32'h0);
        chk("cnt_rd_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
`ifdef OPB_REG_P2S_WRCOUNT_EN
        chk("cnt_rd", bus.Sl_DBus, 32'd2);
`else
        chk("cnt_rd", bus.Sl_DBus, 32'd0);
`endif
        settle("cnt_rd");

`ifdef OPB_REG_P2S_WRCOUNT_EN
        @(negedge clk);
        force dut.wr_count = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.wr_count;
        xfer(32'h4, 1'b1, 4'b1111, 32'h0);
        chk("cnt_pre_wrap", bus.Sl_DBus, 32'hFFFFFFFF);
        settle("cnt_pre_wrap");
        xfer(32'h0, 1'b0, 4'b1000, 32'hAB000000);
        settle("cnt_wrap_wr");
        xfer(32'h4, 1'b1, 4'b1111, 32'h0);
        chk("cnt_wrap", bus.Sl_DBus, 32'd0);
        settle("cnt_wrap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
